// File: rtl/pgs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pgs_pkg
// Description : State encodings, default timing constants and output decode
//               for the ALU-domain power gate sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package pgs_pkg;

    localparam logic [3:0] c_ST_ON      = 4'd0;
    localparam logic [3:0] c_ST_CLK_OFF = 4'd1;
    localparam logic [3:0] c_ST_ISO     = 4'd2;
    localparam logic [3:0] c_ST_SAVE    = 4'd3;
    localparam logic [3:0] c_ST_SW_OFF  = 4'd4;
    localparam logic [3:0] c_ST_OFF     = 4'd5;
    localparam logic [3:0] c_ST_SW_ON   = 4'd6;
    localparam logic [3:0] c_ST_RESTORE = 4'd7;
    localparam logic [3:0] c_ST_DE_ISO  = 4'd8;
    localparam logic [3:0] c_ST_CLK_ON  = 4'd9;

    localparam int c_ISO_SETUP_CYC_DEF = 2;
    localparam int c_RAMP_TIMEOUT_DEF  = 16;
    localparam int c_MIN_OFF_CYC_DEF   = 4;
    localparam int c_CNT_W_DEF         = 8;

    typedef struct packed {
        logic clk_en;
        logic iso_en;
        logic ret_save;
        logic ret_restore;
        logic pwr_sw_en;
        logic domain_ready;
    } pgs_out_t;

    // Physical control levels implied by a state; registered one cycle later.
    function automatic pgs_out_t decode_state(input logic [3:0] st);
        pgs_out_t o;
        o.clk_en       = (st == c_ST_ON) || (st == c_ST_CLK_ON);
        o.iso_en       = (st >= c_ST_ISO) && (st <= c_ST_RESTORE);
        o.ret_save     = (st == c_ST_SAVE);
        o.ret_restore  = (st == c_ST_RESTORE);
        o.pwr_sw_en    = !((st == c_ST_SW_OFF) || (st == c_ST_OFF));
        o.domain_ready = (st == c_ST_ON);
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/power_gate_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : power_gate_sequencer_if
// Description : Request/ack inputs and physical power controls of the gated
//               ALU domain. PGS_STATS_EN adds the statistics counters.
// Revision    : 1.0  initial release
// ============================================================================
interface power_gate_sequencer_if #(
    parameter int CNT_W = 8
);
    logic       pwr_req;
    logic       sw_ack;
    logic       clk_en;
    logic       iso_en;
    logic       ret_save;
    logic       ret_restore;
    logic       pwr_sw_en;
    logic       domain_ready;
    logic       seq_err;
    logic [3:0] pg_state;
`ifdef PGS_STATS_EN
    logic [CNT_W-1:0] off_cycles_o;
    logic [CNT_W-1:0] gate_events_o;
`endif

    modport master (
        output pwr_req,
        output sw_ack,
        input  clk_en,
        input  iso_en,
        input  ret_save,
        input  ret_restore,
        input  pwr_sw_en,
        input  domain_ready,
        input  seq_err,
        input  pg_state
`ifdef PGS_STATS_EN
        ,
        input  off_cycles_o,
        input  gate_events_o
`endif
    );

    modport slave (
        input  pwr_req,
        input  sw_ack,
        output clk_en,
        output iso_en,
        output ret_save,
        output ret_restore,
        output pwr_sw_en,
        output domain_ready,
        output seq_err,
        output pg_state
`ifdef PGS_STATS_EN
        ,
        output off_cycles_o,
        output gate_events_o
`endif
    );

endinterface
`default_nettype wire

// File: rtl/pgs_timer.sv
`default_nettype none
// ============================================================================
// Module      : pgs_timer
// Description : Loadable down-counter that saturates at zero; shared by the
//               isolation setup, OFF dwell and switch-ramp timeout phases.
// Revision    : 1.0  initial release
// ============================================================================
module pgs_timer #(
    parameter int W = 8
) (
    input  wire          clk,
    input  wire          rst,
    input  wire          load,
    input  wire  [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/power_gate_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : power_gate_sequencer
// Description : Orders clock gating, isolation, retention and the power switch
//               for the ALU domain. Define PGS_STATS_EN for OFF/gate counters.
// Revision    : 1.0  initial release
// ============================================================================
module power_gate_sequencer
    import pgs_pkg::*;
#(
    parameter int ISO_SETUP_CYC = c_ISO_SETUP_CYC_DEF,
    parameter int RAMP_TIMEOUT  = c_RAMP_TIMEOUT_DEF,
    parameter int MIN_OFF_CYC   = c_MIN_OFF_CYC_DEF,
    parameter int CNT_W         = c_CNT_W_DEF
) (
    input  wire                   clk,
    input  wire                   rst,
    power_gate_sequencer_if.slave pg
);

    logic [3:0]       state_q;
    logic [3:0]       state_d;
    pgs_out_t         out_q;
    pgs_out_t         out_d;
    logic             seq_err_q;
    logic             seq_err_d;

    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic [CNT_W-1:0] w_tmr_cnt;
    logic             w_tmr_zero;
    logic             w_tmr_last;

    pgs_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .count    (w_tmr_cnt),
        .zero     (w_tmr_zero)
    );

    // A phase loaded with N occupies exactly N cycles: it ends on the cycle
    // the timer shows 1 (or has already saturated at 0).
    assign w_tmr_last = w_tmr_zero || (w_tmr_cnt == CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        seq_err_d  = seq_err_q;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (state_q)
            c_ST_ON: begin
                if (!pg.pwr_req) state_d = c_ST_CLK_OFF;
            end
            c_ST_CLK_OFF: begin
                if (pg.pwr_req) begin
                    state_d = c_ST_CLK_ON;
                end else begin
                    state_d    = c_ST_ISO;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = CNT_W'(ISO_SETUP_CYC);
                end
            end
            c_ST_ISO: begin
                if (pg.pwr_req)      state_d = c_ST_DE_ISO;
                else if (w_tmr_last) state_d = c_ST_SAVE;
            end
            c_ST_SAVE: begin
                state_d    = c_ST_SW_OFF;
                w_tmr_load = 1'b1;
                w_tmr_val  = CNT_W'(RAMP_TIMEOUT);
            end
            c_ST_SW_OFF: begin
                if (!pg.sw_ack || w_tmr_last) begin
                    state_d    = c_ST_OFF;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = CNT_W'(MIN_OFF_CYC);
                    if (pg.sw_ack) seq_err_d = 1'b1;
                end
            end
            c_ST_OFF: begin
                if (w_tmr_last && pg.pwr_req) begin
                    state_d    = c_ST_SW_ON;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = CNT_W'(RAMP_TIMEOUT);
                end
            end
            c_ST_SW_ON: begin
                if (pg.sw_ack || w_tmr_last) begin
                    state_d = c_ST_RESTORE;
                    if (!pg.sw_ack) seq_err_d = 1'b1;
                end
            end
            c_ST_RESTORE: state_d = c_ST_DE_ISO;
            c_ST_DE_ISO:  state_d = c_ST_CLK_ON;
            c_ST_CLK_ON:  state_d = c_ST_ON;
            default:      state_d = c_ST_ON;
        endcase
        out_d = decode_state(state_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= c_ST_ON;
            out_q     <= decode_state(c_ST_ON);
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign pg.clk_en       = out_q.clk_en;
    assign pg.iso_en       = out_q.iso_en;
    assign pg.ret_save     = out_q.ret_save;
    assign pg.ret_restore  = out_q.ret_restore;
    assign pg.pwr_sw_en    = out_q.pwr_sw_en;
    assign pg.domain_ready = out_q.domain_ready;
    assign pg.seq_err      = seq_err_q;
    assign pg.pg_state     = state_q;

`ifdef PGS_STATS_EN
    logic [CNT_W-1:0] off_cycles_q;
    logic [CNT_W-1:0] off_cycles_d;
    logic [CNT_W-1:0] gate_events_q;
    logic [CNT_W-1:0] gate_events_d;

    always_comb begin
        off_cycles_d  = off_cycles_q;
        gate_events_d = gate_events_q;
        if ((state_q == c_ST_OFF) && (off_cycles_q != '1)) begin
            off_cycles_d = off_cycles_q + CNT_W'(1);
        end
        if ((state_d == c_ST_SAVE) && (state_q != c_ST_SAVE) && (gate_events_q != '1)) begin
            gate_events_d = gate_events_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_cycles_q  <= '0;
            gate_events_q <= '0;
        end else begin
            off_cycles_q  <= off_cycles_d;
            gate_events_q <= gate_events_d;
        end
    end

    assign pg.off_cycles_o  = off_cycles_q;
    assign pg.gate_events_o = gate_events_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_power_gate_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_power_gate_sequencer
// Description : Directed + random stimulus against a dwell-counting reference
//               model; a monitor pops per-cycle expectations from a queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_power_gate_sequencer;

    localparam int c_ISO  = 2;
    localparam int c_RAMP = 16;
    localparam int c_MIN  = 4;
    localparam int c_CW   = 8;

    localparam int P_ON = 0, P_CLK_OFF = 1, P_ISO = 2, P_SAVE = 3, P_SW_OFF = 4;
    localparam int P_OFF = 5, P_SW_ON = 6, P_RESTORE = 7, P_DE_ISO = 8, P_CLK_ON = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    power_gate_sequencer_if #(.CNT_W(c_CW)) pg ();

    power_gate_sequencer #(
        .ISO_SETUP_CYC (c_ISO),
        .RAMP_TIMEOUT  (c_RAMP),
        .MIN_OFF_CYC   (c_MIN),
        .CNT_W         (c_CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pg  (pg)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    int          m_ph;
    int          m_dwell;
    logic        m_err;
    logic [5:0]  m_out;
    int          m_off;
    int          m_gate;

    logic        ack_stuck;
    int          ack_cnt;
    int          ack_lag;

    // {clk_en, iso_en, ret_save, ret_restore, pwr_sw_en, domain_ready}
    function automatic logic [5:0] ph_out(input int ph);
        logic [5:0] o;
        o[5] = (ph == P_ON) || (ph == P_CLK_ON);
        o[4] = (ph == P_ISO) || (ph == P_SAVE) || (ph == P_SW_OFF) ||
               (ph == P_OFF) || (ph == P_SW_ON) || (ph == P_RESTORE);
        o[3] = (ph == P_SAVE);
        o[2] = (ph == P_RESTORE);
        o[1] = !((ph == P_SW_OFF) || (ph == P_OFF));
        o[0] = (ph == P_ON);
        return o;
    endfunction

    function automatic logic [31:0] pack(input int ph, input logic [5:0] o, input logic err,
                                         input int offc, input int gatec);
        logic [31:0] v;
        logic [31:0] p;
        logic [31:0] a;
        logic [31:0] g;
        p = ph;
        a = offc;
        g = gatec;
        v = '0;
        v[10:0] = {p[3:0], o, err};
`ifdef PGS_STATS_EN
        v[18:11] = a[7:0];
        v[26:19] = g[7:0];
`else
        a = '0;
        g = '0;
        v[26:11] = {a[7:0], g[7:0]};
`endif
        return v;
    endfunction

    function automatic logic [31:0] obs();
        logic [31:0] v;
        v = '0;
        v[10:0] = {pg.pg_state, pg.clk_en, pg.iso_en, pg.ret_save, pg.ret_restore,
                   pg.pwr_sw_en, pg.domain_ready, pg.seq_err};
`ifdef PGS_STATS_EN
        v[18:11] = pg.off_cycles_o;
        v[26:19] = pg.gate_events_o;
`endif
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got state=%0d outs=%b err=%b stats=%h, expected state=%0d outs=%b err=%b stats=%h",
                     nm, $time, act[10:7], act[6:1], act[0], act[26:11],
                     exp[10:7], exp[6:1], exp[0], exp[26:11]);
        end
    endtask

    task automatic model_reset();
        m_ph    = P_ON;
        m_dwell = 1;
        m_out   = ph_out(P_ON);
        m_err   = 1'b0;
        m_off   = 0;
        m_gate  = 0;
    endtask

    // m_dwell = cycles already spent in the current phase, counting this one.
    task automatic model_step(input logic req, input logic ack);
        int   nx;
        logic ne;
        nx = m_ph;
        ne = m_err;
        case (m_ph)
            P_ON:      if (!req) nx = P_CLK_OFF;
            P_CLK_OFF: nx = req ? P_CLK_ON : P_ISO;
            P_ISO:     if (req) nx = P_DE_ISO; else if (m_dwell >= c_ISO) nx = P_SAVE;
            P_SAVE:    nx = P_SW_OFF;
            P_SW_OFF:  if (!ack) nx = P_OFF;
                       else if (m_dwell >= c_RAMP) begin nx = P_OFF; ne = 1'b1; end
            P_OFF:     if (req && m_dwell >= c_MIN) nx = P_SW_ON;
            P_SW_ON:   if (ack) nx = P_RESTORE;
                       else if (m_dwell >= c_RAMP) begin nx = P_RESTORE; ne = 1'b1; end
            P_RESTORE: nx = P_DE_ISO;
            P_DE_ISO:  nx = P_CLK_ON;
            P_CLK_ON:  nx = P_ON;
            default:   nx = P_ON;
        endcase
        if (m_ph == P_OFF && m_off < 255) m_off++;
        if (nx == P_SAVE && m_ph != P_SAVE && m_gate < 255) m_gate++;
        m_out   = ph_out(m_ph);
        m_dwell = (nx == m_ph) ? ((m_dwell < 1000) ? m_dwell + 1 : m_dwell) : 1;
        m_ph    = nx;
        m_err   = ne;
        exp_q.push_back(pack(m_ph, m_out, m_err, m_off, m_gate));
    endtask

    // Rail emulation: sw_ack follows pwr_sw_en after ack_lag cycles unless stuck.
    task automatic drive(input logic req);
        pg.pwr_req = req;
        if (!ack_stuck && (pg.sw_ack != pg.pwr_sw_en)) begin
            ack_cnt++;
            if (ack_cnt >= ack_lag) begin
                pg.sw_ack = pg.pwr_sw_en;
                ack_cnt   = 0;
            end
        end else begin
            ack_cnt = 0;
        end
        model_step(req, pg.sw_ack);
    endtask

    task automatic step(input logic req);
        @(negedge clk);
        drive(req);
    endtask

    task automatic do_async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", obs(), pack(P_ON, ph_out(P_ON), 1'b0, 0, 0));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(1'b1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) check("cycle", obs(), exp_q.pop_front());
        end
    end

    initial begin
        int   seg;
        logic rreq;
        pg.pwr_req = 1'b1;
        pg.sw_ack  = 1'b1;
        rst        = 1'b0;
        ack_stuck  = 1'b0;
        ack_cnt    = 0;
        ack_lag    = 3;
        model_reset();
        #1 rst = 1'b1;
        #1 check("reset_state", obs(), pack(P_ON, ph_out(P_ON), 1'b0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1);
        repeat (19) step(1'b1);

        ack_lag = 3;
        repeat (30) step(1'b0);
        ack_lag = 2;
        repeat (30) step(1'b1);

        step(1'b0);
        repeat (10) step(1'b1);

        ack_stuck = 1'b1;
        repeat (40) step(1'b0);
        ack_stuck = 1'b0;
        ack_lag   = 2;
        repeat (30) step(1'b1);

        repeat (25) step(1'b0);
        do_async_reset();
        repeat (20) step(1'b1);

        seg  = 0;
        rreq = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (seg == 0) begin
                rreq      = 1'($urandom_range(0, 1));
                seg       = int'($urandom_range(1, 30));
                ack_stuck = ($urandom_range(0, 9) == 0);
            end
            seg--;
            if (ack_cnt == 0) ack_lag = ($urandom_range(0, 4) == 0) ? 20 : int'($urandom_range(1, 4));
            if ((i % 500) == 499) do_async_reset();
            else                  step(rreq);
        end

        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
